// File: rtl/axis_i2c_arbiter.sv
// Round-robin arbiter that picks one AXI-Stream command at a time from NUM_REQ requesters and sends it to a single I2C master port.
// Latency: s_tready pulses combinationally in the cycle the winner is picked; m_tvalid rises on the next cycle.
// Backpressure: while ISSUE waits on m_tready and during the GAP guard time, every s_tready is held at 0.
//
// Ports:
//   clk, arstn          clock (rising edge); asynchronous active-low reset
//   s_tvalid/s_tdata    per-requester commands; requester i owns s_tdata[i*W +: W]
//   s_tready            one-hot (or zero) accept, driven only while IDLE
//   m_tvalid/m_tdata    command presented to the I2C master; m_tready is its accept
//   grant_id            index of the most recently granted requester
//   busy                high whenever the FSM is not IDLE
//   timeout_err         one-cycle pulse when an issue is abandoned
// Optional feature: define AXIS_I2C_ARB_TIMEOUT_EN to drop a command that waits
// TIMEOUT_CYCLES in ISSUE without m_tready. When it is not defined, timeout_err is tied to 0.
module axis_i2c_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int AXIS_DATA_WIDTH = 16,
  parameter int GAP_CYCLES      = 32,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                               clk,
  input  logic                               arstn,
  input  logic [NUM_REQ-1:0]                 s_tvalid,
  input  logic [NUM_REQ*AXIS_DATA_WIDTH-1:0] s_tdata,
  output logic [NUM_REQ-1:0]                 s_tready,
  output logic                               m_tvalid,
  output logic [AXIS_DATA_WIDTH-1:0]         m_tdata,
  input  logic                               m_tready,
  output logic [$clog2(NUM_REQ)-1:0]         grant_id,
  output logic                               busy,
  output logic                               timeout_err
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int GW  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

  // With GAP_CYCLES=0, a finished or abandoned issue goes straight back to IDLE.
  localparam state_t        POST_ISSUE = (GAP_CYCLES == 0) ? IDLE : GAP;
  localparam logic [GW-1:0] GAP_LOAD   = (GAP_CYCLES == 0) ? '0 : GW'(GAP_CYCLES - 1);

  // Illegal parameter values stop elaboration here instead of building broken hardware.
  generate
    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
      $error("axis_i2c_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
    end
  endgenerate

  state_t                     state_q, state_d;
  logic [IDW-1:0]             grant_q, grant_d;
  logic [AXIS_DATA_WIDTH-1:0] mdata_q, mdata_d;
  logic [GW-1:0]              gap_q, gap_d;

  logic                       found;
  logic [IDW-1:0]             winner;
  logic [IDW-1:0]             cand;
  logic [AXIS_DATA_WIDTH-1:0] win_data;

`ifdef AXIS_I2C_ARB_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          terr_q, terr_d;
`endif

  // Round-robin search. It starts one index past the last grant and wraps around,
  // so the requester that was just served has the lowest priority next time.
  always_comb begin
    found  = 1'b0;
    winner = grant_q;
    cand   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IDW'((int'(grant_q) + i) % NUM_REQ);
      if (!found && s_tvalid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // Data mux indexed by a constant loop variable, so no variable part-select is needed.
  always_comb begin
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IDW'(i) == winner) win_data = s_tdata[i*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH];
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    mdata_d  = mdata_q;
    gap_d    = gap_q;
    s_tready = '0;
`ifdef AXIS_I2C_ARB_TIMEOUT_EN
    to_cnt_d = to_cnt_q;
    terr_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (found) begin
          // Gated by arstn so that s_tready reads 0 while reset is held.
          s_tready[winner] = arstn;
          grant_d          = winner;
          mdata_d          = win_data;
          state_d          = ISSUE;
`ifdef AXIS_I2C_ARB_TIMEOUT_EN
          to_cnt_d         = '0;
`endif
        end
      end
      ISSUE: begin
        if (m_tready) begin
          state_d = POST_ISSUE;
          gap_d   = GAP_LOAD;
        end
`ifdef AXIS_I2C_ARB_TIMEOUT_EN
        else if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          // This is the last ISSUE cycle allowed: drop the command and take the normal guard gap.
          state_d = POST_ISSUE;
          gap_d   = GAP_LOAD;
          terr_d  = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
`endif
      end
      GAP: begin
        if (gap_q == '0) state_d = IDLE;
        else             gap_d   = gap_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q  <= IDLE;
      grant_q  <= IDW'(NUM_REQ - 1);
      mdata_q  <= '0;
      gap_q    <= '0;
`ifdef AXIS_I2C_ARB_TIMEOUT_EN
      to_cnt_q <= '0;
      terr_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      mdata_q  <= mdata_d;
      gap_q    <= gap_d;
`ifdef AXIS_I2C_ARB_TIMEOUT_EN
      to_cnt_q <= to_cnt_d;
      terr_q   <= terr_d;
`endif
    end
  end

  assign m_tvalid = (state_q == ISSUE);
  assign m_tdata  = mdata_q;
  assign grant_id = grant_q;
  assign busy     = (state_q != IDLE);
`ifdef AXIS_I2C_ARB_TIMEOUT_EN
  assign timeout_err = terr_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule
